cmp_location_feeder: RTL and testbench

- Transmit-side companion to the max/location compare path.
- Accepts a row-major score stream from the PE array and tags each score with a packed {row, col} location.
- Drives the comparator's en/clear/start/mode/value/location inputs, then flushes the compare pipeline.
- Captures the final max and its location and presents it as a one-cycle result pulse to the CIGAR/traceback controller.

---
 rtl/cmp_feeder_pkg.sv | 40 ++++
 rtl/cmp_loc_counter.sv | 63 ++++++
 rtl/cmp_location_feeder.sv | 190 +++++++++++++++++++
 tb/tb_cmp_location_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmp_feeder_pkg: state encoding, location pack/unpack, score floor   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cmp_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Most negative score for a w-bit two's-complement value (low w bits valid).
  function automatic logic [63:0] cmp_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  localparam int CMP_WIDTH_DEFAULT = 16;
  localparam logic [CMP_WIDTH_DEFAULT-1:0] CMP_MIN = CMP_WIDTH_DEFAULT'(cmp_min(CMP_WIDTH_DEFAULT));

  function automatic logic [63:0] pack_loc(input logic [31:0] row, input logic [31:0] col,
                                           input int unsigned col_w);
    return ({32'd0, row} << col_w) | {32'd0, col};
  endfunction

  function automatic logic [31:0] unpack_col(input logic [63:0] loc, input int unsigned col_w);
    logic [63:0] mask;
    mask = (64'd1 << col_w) - 64'd1;
    return 32'(loc & mask);
  endfunction

  function automatic logic [31:0] unpack_row(input logic [63:0] loc, input int unsigned col_w);
    return 32'(loc >> col_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_loc_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmp_loc_counter: row/col position of the score stream, sticky ovf  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cmp_loc_counter #(
  parameter int ROW_WIDTH = 16,
  parameter int COL_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic                 last_col,
  output logic [ROW_WIDTH-1:0] row,
  output logic [COL_WIDTH-1:0] col,
  output logic                 col_ovf
);

  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ovf_d = ovf_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      ovf_d = 1'b0;
    end else if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + ROW_WIDTH'(1);
      end else if (&col_q) begin
        // A row longer than the column space: wrap and flag it.
        col_d = '0;
        ovf_d = 1'b1;
      end else begin
        col_d = col_q + COL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_q <= '0;
      col_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      ovf_q <= ovf_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign col_ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/cmp_location_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cmp_location_feeder: tags scores with {row,col}, drives and drains |
// | the max/location comparator, returns the final max as a pulse.     |
// | Option macro: CMP_FEEDER_CLAMP_NEG_EN (floor scores/filler at 0).  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cmp_location_feeder
  import cmp_feeder_pkg::*;
#(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int COL_WIDTH      = 16,
  parameter int DRAIN_CYCLES   = 7
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        start,
  input  logic                        mode,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [CMP_WIDTH-1:0] s_score,
  input  logic                        s_last_col,
  input  logic                        s_last_row,
  output logic                        cmp_en,
  output logic                        cmp_clear,
  output logic                        cmp_start,
  output logic                        cmp_mode,
  output logic signed [CMP_WIDTH-1:0] cmp_value,
  output logic [LOCATION_WIDTH-1:0]   cmp_location,
  input  logic signed [CMP_WIDTH-1:0] cmp_max,
  input  logic [LOCATION_WIDTH-1:0]   cmp_loc_in,
  output logic                        res_valid,
  output logic signed [CMP_WIDTH-1:0] res_max,
  output logic [LOCATION_WIDTH-1:0]   res_loc,
  output logic                        busy,
  output logic                        col_ovf
);

  localparam int ROW_WIDTH = LOCATION_WIDTH - COL_WIDTH;
  localparam int DRAIN_W   = $clog2(DRAIN_CYCLES + 1);

`ifdef CMP_FEEDER_CLAMP_NEG_EN
  localparam logic [CMP_WIDTH-1:0] FILL_VALUE = '0;
`else
  localparam logic [CMP_WIDTH-1:0] FILL_VALUE = CMP_WIDTH'(cmp_min(CMP_WIDTH));
`endif

  state_t                      state_q, state_d;
  logic [DRAIN_W-1:0]          drain_q, drain_d;
  logic                        s_ready_q, s_ready_d;
  logic                        cmp_en_q, cmp_en_d;
  logic                        cmp_clear_q, cmp_clear_d;
  logic                        cmp_start_q, cmp_start_d;
  logic                        cmp_mode_q, cmp_mode_d;
  logic [CMP_WIDTH-1:0]        cmp_value_q, cmp_value_d;
  logic [LOCATION_WIDTH-1:0]   cmp_location_q, cmp_location_d;
  logic                        res_valid_q, res_valid_d;
  logic [CMP_WIDTH-1:0]        res_max_q, res_max_d;
  logic [LOCATION_WIDTH-1:0]   res_loc_q, res_loc_d;
  logic                        busy_q, busy_d;

  logic                        accept;
  logic [CMP_WIDTH-1:0]        score_in;
  logic [ROW_WIDTH-1:0]        row;
  logic [COL_WIDTH-1:0]        col;
  logic [LOCATION_WIDTH-1:0]   loc_now;

`ifdef CMP_FEEDER_CLAMP_NEG_EN
  assign score_in = s_score[CMP_WIDTH-1] ? '0 : s_score;
`else
  assign score_in = s_score;
`endif

  assign loc_now = LOCATION_WIDTH'(pack_loc(32'(row), 32'(col), COL_WIDTH));

  cmp_loc_counter #(
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH)
  ) u_loc_counter (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clear    (state_d == CLEAR),
    .advance  (accept),
    .last_col (s_last_col),
    .row      (row),
    .col      (col),
    .col_ovf  (col_ovf)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN: begin
        // start wins over a beat presented in the same cycle
        if (start) begin
          state_d = CLEAR;
        end else if (s_valid && s_ready_q) begin
          accept = 1'b1;
          if (s_last_col && s_last_row) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        if (start) begin
          state_d = CLEAR;
        end else if (drain_q <= DRAIN_W'(1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered and aligned to the state they belong to.
  always_comb begin
    s_ready_d      = (state_d == RUN);
    busy_d         = (state_d != IDLE);
    cmp_clear_d    = (state_d == CLEAR);
    cmp_start_d    = (state_d == CLEAR);
    cmp_mode_d     = (state_d == CLEAR) ? mode : cmp_mode_q;
    cmp_en_d       = accept || (state_d == DRAIN);
    cmp_value_d    = cmp_value_q;
    cmp_location_d = cmp_location_q;
    if (accept) begin
      cmp_value_d    = score_in;
      cmp_location_d = loc_now;
    end else if (state_d == DRAIN) begin
      cmp_value_d    = FILL_VALUE;
    end
    res_valid_d = (state_q == DONE);
    res_max_d   = (state_q == DONE) ? cmp_max    : res_max_q;
    res_loc_d   = (state_q == DONE) ? cmp_loc_in : res_loc_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      drain_q        <= '0;
      s_ready_q      <= 1'b0;
      busy_q         <= 1'b0;
      cmp_en_q       <= 1'b0;
      cmp_clear_q    <= 1'b0;
      cmp_start_q    <= 1'b0;
      cmp_mode_q     <= 1'b0;
      cmp_value_q    <= '0;
      cmp_location_q <= '0;
      res_valid_q    <= 1'b0;
      res_max_q      <= '0;
      res_loc_q      <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      s_ready_q      <= s_ready_d;
      busy_q         <= busy_d;
      cmp_en_q       <= cmp_en_d;
      cmp_clear_q    <= cmp_clear_d;
      cmp_start_q    <= cmp_start_d;
      cmp_mode_q     <= cmp_mode_d;
      cmp_value_q    <= cmp_value_d;
      cmp_location_q <= cmp_location_d;
      res_valid_q    <= res_valid_d;
      res_max_q      <= res_max_d;
      res_loc_q      <= res_loc_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign cmp_en       = cmp_en_q;
  assign cmp_clear    = cmp_clear_q;
  assign cmp_start    = cmp_start_q;
  assign cmp_mode     = cmp_mode_q;
  assign cmp_value    = cmp_value_q;
  assign cmp_location = cmp_location_q;
  assign res_valid    = res_valid_q;
  assign res_max      = res_max_q;
  assign res_loc      = res_loc_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_location_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cmp_location_feeder: scoreboard bench with a comparator model   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cmp_location_feeder;

  localparam int W  = 16;
  localparam int LW = 32;
  localparam logic signed [W-1:0] MIN_S = 16'sh8000;
`ifdef CMP_FEEDER_CLAMP_NEG_EN
  localparam logic signed [W-1:0] FILL = '0;
`else
  localparam logic signed [W-1:0] FILL = MIN_S;
`endif

  typedef struct packed {
    logic [W-1:0]  value;
    logic [LW-1:0] loc;
  } beat_t;

  logic sys_clk = 1'b0, sys_rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic s_valid = 1'b0, s_last_col = 1'b0, s_last_row = 1'b0;
  logic signed [W-1:0] s_score = '0;

  logic s_ready, cmp_en, cmp_clear, cmp_start, cmp_mode, res_valid, busy, col_ovf;
  logic signed [W-1:0] cmp_value, res_max;
  logic [LW-1:0] cmp_location, res_loc;

  logic n_s_ready, n_cmp_en, n_cmp_clear, n_cmp_start, n_cmp_mode, n_res_valid, n_busy, n_col_ovf;
  logic signed [W-1:0] n_cmp_value, n_res_max;
  logic [LW-1:0] n_cmp_location, n_res_loc;

  logic signed [W-1:0] m_max;
  logic [LW-1:0]       m_loc;
  logic [6:1]          d_en;
  logic signed [W-1:0] d_val [1:6];
  logic [LW-1:0]       d_loc [1:6];

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  beat_t res_q[$];

  always #5 sys_clk = ~sys_clk;

  cmp_location_feeder #(.CMP_WIDTH(W), .LOCATION_WIDTH(LW), .COL_WIDTH(16), .DRAIN_CYCLES(7)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score),
    .s_last_col(s_last_col), .s_last_row(s_last_row),
    .cmp_en(cmp_en), .cmp_clear(cmp_clear), .cmp_start(cmp_start), .cmp_mode(cmp_mode),
    .cmp_value(cmp_value), .cmp_location(cmp_location),
    .cmp_max(m_max), .cmp_loc_in(m_loc),
    .res_valid(res_valid), .res_max(res_max), .res_loc(res_loc),
    .busy(busy), .col_ovf(col_ovf)
  );

  // Narrow-column instance sharing the stimulus, used for overflow checks.
  cmp_location_feeder #(.CMP_WIDTH(W), .LOCATION_WIDTH(LW), .COL_WIDTH(2), .DRAIN_CYCLES(7)) dut_narrow (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .s_valid(s_valid), .s_ready(n_s_ready), .s_score(s_score),
    .s_last_col(s_last_col), .s_last_row(s_last_row),
    .cmp_en(n_cmp_en), .cmp_clear(n_cmp_clear), .cmp_start(n_cmp_start), .cmp_mode(n_cmp_mode),
    .cmp_value(n_cmp_value), .cmp_location(n_cmp_location),
    .cmp_max(m_max), .cmp_loc_in(m_loc),
    .res_valid(n_res_valid), .res_max(n_res_max), .res_loc(n_res_loc),
    .busy(n_busy), .col_ovf(n_col_ovf)
  );

  // Comparator model: 6 delay stages then a compare register, first max wins ties.
  always @(posedge sys_clk) begin
    if (sys_rst || cmp_clear) begin
      d_en <= '0;
      if (sys_rst || !cmp_mode) begin
        m_max <= MIN_S;
        m_loc <= '0;
      end
    end else begin
      d_en     <= {d_en[5:1], cmp_en};
      d_val[1] <= cmp_value;
      d_loc[1] <= cmp_location;
      for (int i = 2; i <= 6; i++) begin
        d_val[i] <= d_val[i-1];
        d_loc[i] <= d_loc[i-1];
      end
      if (d_en[6] && (d_val[6] > m_max)) begin
        m_max <= d_val[6];
        m_loc <= d_loc[6];
      end
    end
  end

  always @(negedge sys_clk) begin
    beat_t e;
    if (!sys_rst) begin
      if (cmp_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmp_beat: unexpected cmp_en value=%0d loc=%h, required none", cmp_value, cmp_location);
        end else begin
          e = exp_q.pop_front();
          if (cmp_value !== e.value || cmp_location !== e.loc) begin
            errors++;
            $display("FAIL cmp_beat: got value=%0d loc=%h, required value=%0d loc=%h",
                     cmp_value, cmp_location, $signed(e.value), e.loc);
          end
        end
      end
      if (res_valid) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected res_valid max=%0d loc=%h", res_max, res_loc);
        end else begin
          e = res_q.pop_front();
          if (res_max !== e.value || res_loc !== e.loc || busy !== 1'b0) begin
            errors++;
            $display("FAIL result: got max=%0d loc=%h busy=%b, required max=%0d loc=%h busy=0",
                     res_max, res_loc, busy, $signed(e.value), e.loc);
          end
        end
      end
    end
  end

  function automatic logic signed [W-1:0] exp_score(input logic signed [W-1:0] s);
`ifdef CMP_FEEDER_CLAMP_NEG_EN
    return (s < 0) ? '0 : s;
`else
    return s;
`endif
  endfunction

  task automatic push_fill(input int n, input logic [LW-1:0] loc);
    beat_t b;
    b.value = FILL;
    b.loc   = loc;
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic push_result(input logic signed [W-1:0] mx, input logic [LW-1:0] loc);
    beat_t b;
    b.value = mx;
    b.loc   = loc;
    res_q.push_back(b);
  endtask

  task automatic send_beat(input logic signed [W-1:0] s, input logic lc, input logic lr,
                           input logic [LW-1:0] loc);
    beat_t b;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL s_ready_run: got %b required 1", s_ready);
    end
    s_valid = 1'b1; s_score = s; s_last_col = lc; s_last_row = lr;
    b.value = exp_score(s);
    b.loc   = loc;
    exp_q.push_back(b);
    @(posedge sys_clk); #1;
    s_valid = 1'b0; s_last_col = 1'b0; s_last_row = 1'b0;
  endtask

  task automatic start_alignment(input logic m);
    start = 1'b1; mode = m;
    @(posedge sys_clk); #1;
    start = 1'b0;
    checks++;
    if ({cmp_clear, cmp_start, cmp_en, busy, s_ready, cmp_mode} !== {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, m}) begin
      errors++;
      $display("FAIL clear_state: got clr/st/en/busy/rdy/mode=%b%b%b%b%b%b required 11010%b",
               cmp_clear, cmp_start, cmp_en, busy, s_ready, cmp_mode, m);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (res_q.size() != 0 && n < 40) begin
      @(posedge sys_clk); #1;
      n++;
    end
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending results required 0", name, res_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_beats: got %0d unseen beats required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({s_ready, cmp_en, cmp_clear, cmp_start, cmp_mode, busy, col_ovf, res_valid} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {s_ready, cmp_en, cmp_clear, cmp_start, cmp_mode, busy, col_ovf, res_valid});
    end
    checks++;
    if ({cmp_value, cmp_location, res_max, res_loc} !== '0) begin
      errors++;
      $display("FAIL reset_data: got val=%h loc=%h max=%h rloc=%h required 0",
               cmp_value, cmp_location, res_max, res_loc);
    end
    checks++;
    if ({n_s_ready, n_cmp_en, n_cmp_clear, n_cmp_start, n_cmp_mode, n_busy, n_col_ovf, n_res_valid,
         n_cmp_value, n_cmp_location, n_res_max, n_res_loc} !== '0) begin
      errors++;
      $display("FAIL reset_narrow: got nonzero output, required all 0");
    end
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b s_ready=%b required 0 0", busy, s_ready);
    end
  endtask

  task automatic test_grid();
    int cnt = 0;
    logic signed [W-1:0] sc [6] = '{16'sd5, -16'sd2, 16'sd9, 16'sd1, 16'sd12, 16'sd3};
    start_alignment(1'b0);
    push_result(16'sd12, 32'h0001_0001);
    for (int i = 0; i < 6; i++)
      send_beat(sc[i], (i % 3) == 2, i >= 3, {16'(i / 3), 16'(i % 3)});
    push_fill(6, 32'h0001_0002);
    while (cmp_en === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge sys_clk); #1;
    end
    checks++;
    if (cnt != 7) begin
      errors++;
      $display("FAIL drain_len: got %0d cmp_en cycles required 7", cnt);
    end
    wait_result("grid");
  endtask

  task automatic test_single();
    start_alignment(1'b0);
    push_result(exp_score(-16'sd7), '0);
    send_beat(-16'sd7, 1'b1, 1'b1, '0);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: got s_ready=%b busy=%b required 0 1", s_ready, busy);
    end
    push_fill(6, '0);
    wait_result("single");
  endtask

  task automatic test_toggle();
    logic [4:0] v = 5'b01101;
    logic signed [W-1:0] sc [5] = '{16'sd3, 16'sd9, 16'sd4, 16'sd6, 16'sd9};
    int col = 0;
    start_alignment(1'b1);
    for (int i = 0; i < 5; i++) begin
      if (v[i]) begin
        send_beat(sc[i], 1'b0, 1'b0, 32'(col));
        col++;
      end else begin
        s_valid = 1'b0; s_score = sc[i];
        @(posedge sys_clk); #1;
      end
      checks++;
      if (cmp_en !== v[i]) begin
        errors++;
        $display("FAIL toggle_en: cycle %0d got %b required %b", i, cmp_en, v[i]);
      end
    end
    push_result(16'sd6, 32'h0000_0002);
    send_beat(16'sd2, 1'b1, 1'b1, 32'(col));
    push_fill(6, 32'(col));
    wait_result("toggle");
  endtask

  task automatic test_abort();
    start_alignment(1'b0);
    send_beat(16'sd8, 1'b0, 1'b0, 32'h0);
    send_beat(16'sd1, 1'b1, 1'b1, 32'h1);
    push_fill(2, 32'h1);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    checks++;
    if ({cmp_clear, cmp_start, cmp_en, busy, res_valid} !== 5'b11010) begin
      errors++;
      $display("FAIL abort_clear: got clr/st/en/busy/res=%b required 11010",
               {cmp_clear, cmp_start, cmp_en, busy, res_valid});
    end
    @(posedge sys_clk); #1;
    push_result(16'sd4, '0);
    send_beat(16'sd4, 1'b1, 1'b1, '0);
    push_fill(6, '0);
    wait_result("abort");
  endtask

  task automatic test_col_ovf();
    logic [LW-1:0] nloc [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    start_alignment(1'b0);
    for (int k = 0; k < 5; k++) begin
      send_beat(16'(k + 1), 1'b0, 1'b0, 32'(k));
      checks++;
      if (n_cmp_location !== nloc[k] || n_col_ovf !== (k >= 3)) begin
        errors++;
        $display("FAIL col_ovf_beat%0d: got loc=%h ovf=%b required loc=%h ovf=%b",
                 k, n_cmp_location, n_col_ovf, nloc[k], (k >= 3));
      end
    end
    push_result(16'sd6, 32'd5);
    send_beat(16'sd6, 1'b1, 1'b1, 32'd5);
    checks++;
    if (n_cmp_location !== 32'd1 || col_ovf !== 1'b0) begin
      errors++;
      $display("FAIL col_ovf_after: got narrow loc=%h wide ovf=%b required 1 0", n_cmp_location, col_ovf);
    end
    push_fill(6, 32'd5);
    wait_result("col_ovf");
  endtask

  task automatic test_rst_in_run();
    start_alignment(1'b0);
    send_beat(16'sd5, 1'b0, 1'b0, '0);
    @(negedge sys_clk); #1;
    s_valid = 1'b1; s_score = 16'sd11; sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    s_valid = 1'b0; sys_rst = 1'b0;
    checks++;
    if ({s_ready, cmp_en, busy, res_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_in_run: got rdy/en/busy/res=%b required 0000", {s_ready, cmp_en, busy, res_valid});
    end
    repeat (20) @(posedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got %0d pending beats busy=%b required 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_grid();
    test_single();
    test_toggle();
    test_abort();
    test_col_ovf();
    test_rst_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
